muldiv_seq: RTL and testbench

Iterative sequencer for the RV32M multiply/divide operations, sitting beside the single-cycle ALU in the EX stage. It accepts an M-extension instruction from EX, runs a 32-step shift-add multiply or restoring divide on latched operands, and stalls the pipeline until the result is ready. It then returns a one-cycle `done` pulse with the 32-bit result for the EX/MEM register mux.

---
 rtl/muldiv_seq_if.sv | 25 ++
 rtl/muldiv_seq.sv | 165 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// EX-stage <-> M-extension sequencer bundle.
// master drives the op, slave returns stall/busy/done/result.
interface muldiv_seq_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            flush;
   logic            stall;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, funct3, op_a, op_b, flush,
      input  stall, busy, done, result
   );

   modport slave (
      input  start, funct3, op_a, op_b, flush,
      output stall, busy, done, result
   );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M sequencer: 32-step shift-add multiply
// and restoring divide, stalling EX until the result is ready.
module muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   muldiv_seq_if.slave  bus
);
   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_f3;
   logic [XLEN-1:0] r_hi;
   logic [XLEN-1:0] r_lo;
   logic [XLEN-1:0] r_d;
   logic [XLEN-1:0] r_result;
   logic            r_neg_q;
   logic            r_neg_r;
   logic            r_done;

   logic [XLEN-1:0]   w_min;
   logic              w_ua;
   logic              w_sa;
   logic              w_sb;
   logic [XLEN-1:0]   w_mag_a;
   logic [XLEN-1:0]   w_mag_b;
   logic              w_dz;
   logic              w_ovf;
   logic [XLEN-1:0]   w_spec;
   logic [XLEN:0]     w_mul_sum;
   logic [XLEN:0]     w_div_sh;
   logic [XLEN:0]     w_div_diff;
   logic              w_div_ge;
   logic [2*XLEN-1:0] w_prod;
   logic [2*XLEN-1:0] w_prod_s;
   logic [XLEN-1:0]   w_quot;
   logic [XLEN-1:0]   w_rem;
   logic [XLEN-1:0]   w_fix;

   assign w_min = {1'b1, {(XLEN-1){1'b0}}};

   // MULHU/DIVU/REMU treat rs1 unsigned; MULHSU also treats rs2 unsigned
   assign w_ua = bus.funct3[0] & (bus.funct3[1] | bus.funct3[2]);
   assign w_sa = bus.op_a[XLEN-1] & ~w_ua;
   assign w_sb = bus.op_b[XLEN-1] & ~w_ua & (bus.funct3 != 3'b010);

   assign w_mag_a = w_sa ? -bus.op_a : bus.op_a;
   assign w_mag_b = w_sb ? -bus.op_b : bus.op_b;

   assign w_dz  = bus.funct3[2] & (bus.op_b == '0);
   assign w_ovf = bus.funct3[2] & ~bus.funct3[0]
                & (bus.op_a == w_min) & (&bus.op_b);

   always_comb begin
      w_spec = w_min;
      unique case (1'b1)
         (w_dz && !bus.funct3[1]): w_spec = '1;
         (w_dz && bus.funct3[1]):  w_spec = bus.op_a;
         (!w_dz && bus.funct3[1]): w_spec = '0;
         default:                  w_spec = w_min;
      endcase
   end

   assign w_mul_sum  = {1'b0, r_hi}
                     + (r_lo[0] ? {1'b0, r_d} : '0);
   assign w_div_sh   = {r_hi, r_lo[XLEN-1]};
   assign w_div_diff = w_div_sh - {1'b0, r_d};
   assign w_div_ge   = ~w_div_diff[XLEN];

   assign w_prod   = {r_hi, r_lo};
   assign w_prod_s = r_neg_q ? -w_prod : w_prod;
   assign w_quot   = r_neg_q ? -r_lo : r_lo;
   assign w_rem    = r_neg_r ? -r_hi : r_hi;

   always_comb begin
      w_fix = w_prod_s[2*XLEN-1:XLEN];
      if (r_f3[2])
         w_fix = r_f3[1] ? w_rem : w_quot;
      else if (r_f3[1:0] == 2'b00)
         w_fix = w_prod_s[XLEN-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_f3     <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_d      <= '0;
         r_result <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (bus.flush) begin
            r_state <= S_IDLE;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  if (bus.start) begin
                     r_f3    <= bus.funct3;
                     r_neg_q <= w_sa ^ w_sb;
                     r_neg_r <= w_sa;
                     r_hi    <= '0;
                     r_lo    <= bus.funct3[2] ? w_mag_a : w_mag_b;
                     r_d     <= bus.funct3[2] ? w_mag_b : w_mag_a;
                     if (w_dz || w_ovf) begin
                        r_result <= w_spec;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                     end else begin
                        r_cnt   <= CW'(XLEN-1);
                        r_state <= S_CALC;
                     end
                  end
               end
               S_CALC: begin
                  if (r_f3[2]) begin
                     r_hi <= w_div_ge ? w_div_diff[XLEN-1:0]
                                      : w_div_sh[XLEN-1:0];
                     r_lo <= {r_lo[XLEN-2:0], w_div_ge};
                  end else begin
                     r_hi <= w_mul_sum[XLEN:1];
                     r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
                  end
                  if (r_cnt == '0)
                     r_state <= S_FIX;
                  else
                     r_cnt <= r_cnt - CW'(1);
               end
               S_FIX: begin
                  r_result <= w_fix;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end
               S_DONE: begin
                  r_state <= S_IDLE;
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.stall  = rst_n & (
                         (r_state == S_IDLE & bus.start & ~bus.flush)
                       | (r_state == S_CALC)
                       | (r_state == S_FIX));
   assign bus.busy   = (r_state != S_IDLE);
   assign bus.done   = r_done;
   assign bus.result = r_result;
endmodule

// File: tb/tb_muldiv_seq.sv
// Randomised bench for muldiv_seq against an arithmetic
// reference model plus hand-computed RV32M vectors.
module tb_muldiv_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;
   int   n_done = 0;

   muldiv_seq_if #(.XLEN(32)) bus ();

   muldiv_seq #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] MIN = 32'h8000_0000;

   function automatic logic [31:0] ref_op(
      input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      int ia, ib;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      ia = $signed(a);
      ib = $signed(b);
      case (f)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
            return ia / ib;
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 0) return a;
            if (a == MIN && b == 32'hFFFF_FFFF) return 32'h0;
            return ia % ib;
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic bit is_special(
      input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (!f[2]) return 1'b0;
      if (b == 0) return 1'b1;
      return !f[0] && a == MIN && b == 32'hFFFF_FFFF;
   endfunction

   task automatic chk(input string name,
                      input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   // Cycle model: an accepted op reports done m_len cycles later
   bit          m_act = 0;
   int          m_k = 0;
   int          m_len = 0;
   logic [31:0] m_pend = '0;
   logic [31:0] m_res = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_act <= 0;
         m_k   <= 0;
         m_res <= '0;
      end else if (bus.flush) begin
         m_act <= 0;
      end else if (m_act) begin
         if (m_k == m_len) begin
            m_act <= 0;
         end else begin
            m_k <= m_k + 1;
            if (m_k + 1 == m_len) m_res <= m_pend;
         end
      end else if (bus.start) begin
         m_act  <= 1;
         m_k    <= 0;
         m_len  <= is_special(bus.funct3, bus.op_a, bus.op_b) ? 0 : 33;
         m_pend <= ref_op(bus.funct3, bus.op_a, bus.op_b);
         if (is_special(bus.funct3, bus.op_a, bus.op_b))
            m_res <= ref_op(bus.funct3, bus.op_a, bus.op_b);
      end
   end

   always @(negedge clk) begin
      chk("busy", 32'(bus.busy), 32'(m_act));
      chk("done", 32'(bus.done), 32'(m_act && m_k == m_len));
      chk("stall", 32'(bus.stall),
          32'(rst_n && ((!m_act && bus.start && !bus.flush)
                        || (m_act && m_k < m_len))));
      chk("result", bus.result, m_res);
      if (bus.done) n_done++;
   end

   task automatic run_op(input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit lit, input logic [31:0] exp,
                         input int exp_cyc, input int exp_stall);
      int cyc;
      int nst;
      bit seen;
      @(posedge clk);
      #2;
      bus.start  = 1'b1;
      bus.funct3 = f;
      bus.op_a   = a;
      bus.op_b   = b;
      @(negedge clk);
      nst  = int'(bus.stall);
      cyc  = -1;
      seen = 0;
      while (!seen && cyc < 60) begin
         @(negedge clk);
         cyc++;
         nst += int'(bus.stall);
         if (bus.done) seen = 1;
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout f3=%0d actual=no_done required=done", f);
      end else if (lit) begin
         chk("lit_result", bus.result, exp);
         chk("lit_done_cycle", 32'(cyc), 32'(exp_cyc));
         chk("lit_stall_cycles", 32'(nst), 32'(exp_stall));
      end
   endtask

   task automatic idle(input int n);
      @(posedge clk);
      #2;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      repeat (n) @(posedge clk);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return MIN;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int d0;
      bus.start  = 1'b0;
      bus.funct3 = '0;
      bus.op_a   = '0;
      bus.op_b   = '0;
      bus.flush  = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, 33, 34);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 33, 34);
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0, 33, 34);
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 33, 34);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD, 33, 34);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 33, 34);
      run_op(3'd5, 32'd100, 32'd7, 1, 32'd14, 33, 34);
      run_op(3'd7, 32'd100, 32'd7, 1, 32'd2, 33, 34);
      run_op(3'd5, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 0, 1);
      run_op(3'd6, 32'd5, 32'd0, 1, 32'd5, 0, 1);
      run_op(3'd4, MIN, 32'hFFFF_FFFF, 1, MIN, 0, 1);
      run_op(3'd6, MIN, 32'hFFFF_FFFF, 1, 32'h0, 0, 1);
      idle(1);

      // start together with flush in IDLE must not be accepted
      #2;
      bus.start  = 1'b1;
      bus.flush  = 1'b1;
      bus.funct3 = 3'd0;
      @(posedge clk);
      #2;
      chk("flush_idle_busy", 32'(bus.busy), 32'h0);
      bus.start = 1'b0;
      bus.flush = 1'b0;

      // flush in cycle 10 of a DIVU
      @(posedge clk);
      #2;
      bus.start  = 1'b1;
      bus.funct3 = 3'd5;
      bus.op_a   = 32'd1000;
      bus.op_b   = 32'd7;
      @(posedge clk);
      repeat (10) @(posedge clk);
      #2;
      bus.flush = 1'b1;
      bus.start = 1'b0;
      @(posedge clk);
      #2;
      bus.flush = 1'b0;
      chk("flush_busy", 32'(bus.busy), 32'h0);
      chk("flush_stall", 32'(bus.stall), 32'h0);
      d0 = n_done;
      repeat (40) @(posedge clk);
      chk("flush_no_done", 32'(n_done - d0), 32'h0);
      run_op(3'd0, 32'd3, 32'd4, 1, 32'd12, 33, 34);
      idle(1);

      // reset mid-CALC
      @(posedge clk);
      #2;
      bus.start  = 1'b1;
      bus.funct3 = 3'd0;
      bus.op_a   = 32'd5;
      bus.op_b   = 32'd6;
      repeat (12) @(posedge clk);
      #2;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      #1;
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_stall", 32'(bus.stall), 32'h0);
      chk("rst_done", 32'(bus.done), 32'h0);
      chk("rst_result", bus.result, 32'h0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      d0 = n_done;
      run_op(3'd7, 32'd20, 32'd6, 1, 32'd2, 33, 34);
      run_op(3'd7, 32'd9, 32'd4, 1, 32'd1, 33, 34);
      idle(3);
      chk("b2b_done_pulses", 32'(n_done - d0), 32'd2);

      for (int i = 0; i < 40; i++) begin
         run_op(3'($urandom_range(0, 7)), pick(), pick(), 0, '0, 0, 0);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 2));
      end
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
